// File: rtl/crypto_sha512_msched_pkg.sv
// -----------------------------------------------------------------------------
// crypto_sha512_msched_pkg
// Shared definitions for the SHA-512 message-schedule engine:
//   - block / schedule sizing constants
//   - engine state encoding
//   - 64-bit rotate helper used by the sigma functions
// No ports (package).
// -----------------------------------------------------------------------------
package crypto_sha512_msched_pkg;

  localparam int SHA512_BLK_WORDS = 16;
  localparam int SHA512_ROUNDS    = 80;
  localparam int SHA512_WORD_W    = 64;
  localparam int SHA512_IDX_W     = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    EMIT = 2'd2
  } sha512_msched_state_t;

  // Rotate right by a constant amount in 1..63.
  function automatic logic [63:0] ror64(input logic [63:0] x, input logic [5:0] n);
    return (x >> n) | (x << (7'd64 - {1'b0, n}));
  endfunction

endpackage

// File: rtl/crypto_sha512_msched_sigma.sv
// -----------------------------------------------------------------------------
// crypto_sha512_sigma
// Purely combinational SHA-512 small-sigma pair for one 64-bit operand.
// Ports:
//   x_i    in  64  operand
//   sig0_o out 64  sigma0(x) = ror(x,1)  ^ ror(x,8)  ^ (x >> 7)
//   sig1_o out 64  sigma1(x) = ror(x,19) ^ ror(x,61) ^ (x >> 6)
// -----------------------------------------------------------------------------
module crypto_sha512_sigma
  import crypto_sha512_msched_pkg::*;
(
  input  logic [63:0] x_i,
  output logic [63:0] sig0_o,
  output logic [63:0] sig1_o
);

  // Both sigma functions of the operand.
  always_comb begin
    sig0_o = ror64(x_i, 6'd1)  ^ ror64(x_i, 6'd8)  ^ (x_i >> 3'd7);
    sig1_o = ror64(x_i, 6'd19) ^ ror64(x_i, 6'd61) ^ (x_i >> 3'd6);
  end

endmodule

// File: rtl/crypto_sha512_msched.sv
// -----------------------------------------------------------------------------
// crypto_sha512_msched
// Sequential SHA-512 message-schedule engine. Loads one 1024-bit block as
// sixteen 64-bit words (word 0 first) and streams W[0..ROUNDS-1] using a
// 16-entry circular buffer; W[t] for t >= 16 overwrites the slot of W[t-16].
// Ports:
//   clk_i        in   1   clock, rising edge
//   rst_i        in   1   asynchronous active-high reset
//   flush_i      in   1   synchronous abort, drops the current block
//   blk_valid_i  in   1   message word offered
//   blk_ready_o  out  1   engine accepts a message word (IDLE/LOAD)
//   blk_word_i   in  64   message word
//   w_valid_o    out  1   schedule word presented (EMIT)
//   w_ready_i    in   1   consumer takes the schedule word
//   w_o          out 64   schedule word W[t]
//   w_idx_o      out  7   index t of w_o
//   w_last_o     out  1   t == ROUNDS-1
//   busy_o       out  1   state is not IDLE
// All outputs depend on registered state only.
// -----------------------------------------------------------------------------
module crypto_sha512_msched
  import crypto_sha512_msched_pkg::*;
#(
  parameter int ROUNDS = SHA512_ROUNDS
)
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        flush_i,
  input  logic        blk_valid_i,
  output logic        blk_ready_o,
  input  logic [63:0] blk_word_i,
  output logic        w_valid_o,
  input  logic        w_ready_i,
  output logic [63:0] w_o,
  output logic [6:0]  w_idx_o,
  output logic        w_last_o,
  output logic        busy_o
);

  localparam logic [6:0] LAST_IDX = 7'(ROUNDS - 1);

  sha512_msched_state_t r_state;
  sha512_msched_state_t w_state_nxt;
  logic [6:0]           r_t;
  logic [6:0]           w_t_nxt;
  logic [3:0]           r_load_cnt;
  logic [3:0]           w_load_cnt_nxt;
  logic [63:0]          r_buf [SHA512_BLK_WORDS];

  logic                 w_buf_we;
  logic [3:0]           w_buf_waddr;
  logic [63:0]          w_buf_wdata;

  // Circular-buffer slots holding W[t-16], W[t-15], W[t-7], W[t-2].
  logic [3:0]           w_slot_m16;
  logic [3:0]           w_slot_m15;
  logic [3:0]           w_slot_m7;
  logic [3:0]           w_slot_m2;

  logic [63:0]          w_s0_x;
  logic [63:0]          w_s1_x;
  logic [63:0]          w_s0;
  logic [63:0]          w_s1;
  logic [63:0]          w_s0_path_sig1_unused;
  logic [63:0]          w_s1_path_sig0_unused;
  logic [63:0]          w_sched;
  logic                 w_emit;
  logic                 w_is_last;

  assign w_slot_m16 = r_t[3:0];
  assign w_slot_m15 = r_t[3:0] + 4'd1;
  assign w_slot_m7  = r_t[3:0] + 4'd9;
  assign w_slot_m2  = r_t[3:0] + 4'd14;

  assign w_s0_x = r_buf[w_slot_m15];
  assign w_s1_x = r_buf[w_slot_m2];

  assign w_emit    = (r_state == EMIT);
  assign w_is_last = (r_t == LAST_IDX);

  // sigma0 operand path: W[t-15]
  crypto_sha512_sigma u_sigma_s0 (
    .x_i    (w_s0_x),
    .sig0_o (w_s0),
    .sig1_o (w_s0_path_sig1_unused)
  );

  // sigma1 operand path: W[t-2]
  crypto_sha512_sigma u_sigma_s1 (
    .x_i    (w_s1_x),
    .sig0_o (w_s1_path_sig0_unused),
    .sig1_o (w_s1)
  );

  // Schedule word: message word for t < 16, modulo-2^64 recurrence otherwise.
  always_comb begin
    w_sched = 64'd0;
    if (r_t < 7'd16) begin
      w_sched = r_buf[w_slot_m16];
    end else begin
      w_sched = w_s1 + r_buf[w_slot_m7] + w_s0 + r_buf[w_slot_m16];
    end
  end

  // Next-state, counter and buffer-write decode; flush overrides any handshake.
  always_comb begin
    w_state_nxt    = r_state;
    w_t_nxt        = r_t;
    w_load_cnt_nxt = r_load_cnt;
    w_buf_we       = 1'b0;
    w_buf_waddr    = r_load_cnt;
    w_buf_wdata    = blk_word_i;
    if (flush_i) begin
      w_state_nxt    = IDLE;
      w_t_nxt        = 7'd0;
      w_load_cnt_nxt = 4'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (blk_valid_i) begin
            w_buf_we       = 1'b1;
            w_buf_waddr    = 4'd0;
            w_load_cnt_nxt = 4'd1;
            w_state_nxt    = LOAD;
          end else begin
            w_state_nxt    = IDLE;
          end
        end
        LOAD: begin
          if (blk_valid_i) begin
            w_buf_we    = 1'b1;
            w_buf_waddr = r_load_cnt;
            if (r_load_cnt == 4'd15) begin
              w_load_cnt_nxt = 4'd0;
              w_t_nxt        = 7'd0;
              w_state_nxt    = EMIT;
            end else begin
              w_load_cnt_nxt = r_load_cnt + 4'd1;
            end
          end else begin
            w_state_nxt = LOAD;
          end
        end
        EMIT: begin
          if (w_ready_i) begin
            // Only computed words replace their W[t-16] slot; the first
            // sixteen are already the buffer contents.
            if (r_t >= 7'd16) begin
              w_buf_we    = 1'b1;
              w_buf_waddr = w_slot_m16;
              w_buf_wdata = w_sched;
            end else begin
              w_buf_we    = 1'b0;
            end
            if (w_is_last) begin
              w_state_nxt = IDLE;
              w_t_nxt     = 7'd0;
            end else begin
              w_t_nxt     = r_t + 7'd1;
            end
          end else begin
            w_state_nxt = EMIT;
          end
        end
        default: begin
          w_state_nxt    = IDLE;
          w_t_nxt        = 7'd0;
          w_load_cnt_nxt = 4'd0;
        end
      endcase
    end
  end

  // State, counters and circular buffer.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= IDLE;
      r_t        <= 7'd0;
      r_load_cnt <= 4'd0;
      for (int i = 0; i < SHA512_BLK_WORDS; i++) begin
        r_buf[i] <= 64'd0;
      end
    end else begin
      r_state    <= w_state_nxt;
      r_t        <= w_t_nxt;
      r_load_cnt <= w_load_cnt_nxt;
      if (w_buf_we) begin
        r_buf[w_buf_waddr] <= w_buf_wdata;
      end
    end
  end

  // Outputs decoded from registered state; w_o reads zero outside EMIT.
  always_comb begin
    blk_ready_o = 1'b1;
    w_valid_o   = 1'b0;
    w_last_o    = 1'b0;
    busy_o      = 1'b0;
    w_o         = 64'd0;
    w_idx_o     = r_t;
    case (r_state)
      IDLE: begin
        blk_ready_o = 1'b1;
        busy_o      = 1'b0;
      end
      LOAD: begin
        blk_ready_o = 1'b1;
        busy_o      = 1'b1;
      end
      EMIT: begin
        blk_ready_o = 1'b0;
        busy_o      = 1'b1;
        w_valid_o   = w_emit;
        w_last_o    = w_is_last;
        w_o         = w_sched;
      end
      default: begin
        blk_ready_o = 1'b1;
        busy_o      = 1'b0;
      end
    endcase
  end

endmodule
